// File: rtl/onehot_decoder_pkg.sv
// Shared sizing for the one-hot decoder: index/output widths, FIFO depth and counter width.
package onehot_decoder_pkg;

   localparam int IDX_W_DEF  = 3;
   localparam int OUT_W_DEF  = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = 16;

   typedef logic [CNT_W-1:0] cnt_t;

   // Occupancy of the two-slot buffer; FIFO_DEPTH is the count held in OCC_FULL.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/onehot_decoder_fifo2.sv
// Two-entry FIFO, no pass-through: ready depends only on registered occupancy.
module fifo2
   import onehot_decoder_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   occ_e         occ, occ_nxt;
   logic         en;
   logic         push, pop;
   logic [W-1:0] slot_head, slot_tail;

   // en keeps in_ready low through reset and releases it on the first clock after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= OCC_EMPTY;
         en  <= 1'b0;
      end else begin
         occ <= occ_nxt;
         en  <= 1'b1;
      end
   end

   assign in_ready  = en && (occ != OCC_FULL);
   assign out_valid = (occ != OCC_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = slot_head;

   always_comb begin
      occ_nxt = occ;
      unique case (occ)
         OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
         OCC_ONE: begin
            if (push && !pop)      occ_nxt = OCC_FULL;
            else if (pop && !push) occ_nxt = OCC_EMPTY;
         end
         OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
         default:   occ_nxt = OCC_EMPTY;
      endcase
   end

   // Data slots carry no reset; validity is owned entirely by occ.
   always_ff @(posedge clk) begin
      unique case (occ)
         OCC_EMPTY: if (push) slot_head <= in_data;
         OCC_ONE: begin
            if (push && pop) slot_head <= in_data;
            else if (push)   slot_tail <= in_data;
         end
         OCC_FULL:  if (pop) slot_head <= slot_tail;
         default: ;
      endcase
   end

endmodule

// File: rtl/onehot_decoder.sv
// Buffers encoded {idx, none} entries, emits them as one-hot vectors, and counts consumed entries.
module onehot_decoder
   import onehot_decoder_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_none,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic [15:0]      dispatch_cnt,
   output logic [15:0]      none_cnt
);

   localparam int EW = IDX_W + 1;

   logic [EW-1:0] head;
   logic          head_none;
   logic [IDX_W-1:0] head_idx;
   logic          pop;
   cnt_t          disp_q, none_q;

   function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] idx, input logic none);
      logic [OUT_W-1:0] one;
      one = {{(OUT_W-1){1'b0}}, 1'b1};
      return none ? '0 : (one << idx);
   endfunction

   fifo2 #(.W(EW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_idx, in_none}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign head_none  = head[0];
   assign head_idx   = head[EW-1:1];
   assign pop        = out_valid && out_ready;
   assign out_onehot = out_valid ? decode(head_idx, head_none) : '0;

   // Counters wrap naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q <= '0;
         none_q <= '0;
      end else if (pop) begin
         disp_q <= disp_q + 1'b1;
         if (head_none) none_q <= none_q + 1'b1;
      end
   end

   assign dispatch_cnt = disp_q;
   assign none_cnt     = none_q;

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 The block SHALL have parameter IDX_W, default 3, meaning encoded index width.
REQ-002 The block SHALL have parameter OUT_W, default 8 (2**IDX_W), meaning one-hot output width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers an encoded index.
REQ-006 in_ready  output  1  block can accept an index this cycle.
REQ-007 in_idx  input  IDX_W  encoded index, matching the priority-encoder output format.
REQ-008 in_none  input  1  upstream had no active request; decodes to all-zero.
REQ-009 out_valid  output  1  out_onehot holds a decoded entry.
REQ-010 out_ready  input  1  downstream consumes the entry this cycle.
REQ-011 out_onehot  output  OUT_W  decoded one-hot vector.
REQ-012 dispatch_cnt  output  16  count of entries consumed downstream.
REQ-013 none_cnt  output  16  count of consumed entries that were all-zero.

Function
REQ-014 The block SHALL buffer accepted {in_idx, in_none} entries in a 2-entry FIFO; in_ready SHALL be 1 iff occupancy < 2.
REQ-015 A push SHALL occur on a rising edge where in_valid & in_ready = 1; a pop SHALL occur where out_valid & out_ready = 1.
REQ-016 out_valid SHALL be 1 iff occupancy > 0; there is no combinational path from in_valid to out_valid (latency 1 cycle from push edge).
REQ-017 out_onehot SHALL equal (1 << head.idx) when head.none = 0 and all-zero when head.none = 1; out_onehot SHALL be 0 when out_valid = 0.
REQ-018 out_onehot SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-019 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 with the new entry at head after the edge.
REQ-020 At occupancy 2, in_ready = 0; a pop SHALL free one slot with in_ready = 1 the following cycle (no same-cycle pass-through).
REQ-021 Pop at occupancy 0 cannot occur; push while in_ready = 0 SHALL be ignored, with no state change.
REQ-022 Entries SHALL leave in acceptance order.
REQ-023 dispatch_cnt SHALL increment by 1 per pop and wrap 0xFFFF -> 0x0000.
REQ-024 none_cnt SHALL increment by 1 per pop whose head.none = 1 and wrap identically.
REQ-025 in_idx SHALL be ignored when in_none = 1.

Reset
REQ-026 Asserting rst_n = 0 SHALL, asynchronously, empty the FIFO: out_valid = 0, out_onehot = 0, in_ready = 0 while in reset.
REQ-027 Reset SHALL clear dispatch_cnt and none_cnt to 0.
REQ-028 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-transfer SHALL discard buffered entries without a pop count.

Structure
REQ-029 IDX_W/OUT_W defaults, FIFO depth (2), and counter width (16) SHALL live in a shared package.
REQ-030 The FIFO SHALL be one sub-module, fifo2, parameterised on entry width (IDX_W+1).
REQ-031 The decode and both counters SHALL reside in onehot_decoder.

Verification
REQ-032 Reset, then push idx=5, none=0 with out_ready=1 -> out_valid=1, out_onehot=8'b0010_0000 the next cycle, dispatch_cnt=1 after the pop.
REQ-033 Push none=1, idx=3 -> out_onehot=8'h00, out_valid=1; after the pop, none_cnt=1.
REQ-034 With out_ready=0, push 2, 7, 0 -> in_ready=0 after two pushes, the third is ignored, and the output holds 8'h04; raising out_ready gives 8'h04 then 8'h80.
REQ-035 Occupancy 1 with simultaneous push idx=1 and pop -> occupancy stays 1 and out_onehot=8'h02.
REQ-036 Preload dispatch_cnt to 0xFFFF via 65535 pops, then one more pop -> dispatch_cnt=0x0000.
REQ-037 Assert rst_n=0 mid-stream with 2 entries -> out_valid=0, out_onehot=0 immediately without a clock, and counters=0.
